cache_arbiter: RTL and testbench

Two-port to one-port arbiter between the instruction-cache miss port and data-cache miss port and the single physical-memory (pmem) interface. Sits below the split L1 caches that feed the pipeline's `cmem_*_a` (fetch) and `cmem_*_b` (data) ports. It serialises cacheline reads and writebacks onto one pmem channel:
- registered request capture;
- round-robin tie-breaking;
- one-cycle response pulses back to the winning cache.

---
 rtl/cache_arbiter.sv | 130 +++++++++++++
 tb/tb_cache_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Brief    : Arbitrates I-cache and D-cache line misses onto a single pmem
//            channel. Requests are captured when granted, ties are broken
//            round-robin, and each completion is a one-cycle resp pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache miss port
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache miss port
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // physical memory port
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE_I = 3'd1,
    ST_SERVE_D = 3'd2,
    ST_RESP_I  = 3'd3,
    ST_RESP_D  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_d_req;
  logic                  r_last_d;     // 1 when the most recent grant went to D
  logic                  r_op_write;   // latched D op: 1 = writeback
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;

  assign w_d_req = d_read | d_write;

  // Next-state and grant decision; requester inputs matter only in IDLE
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_read && w_d_req) begin
          // Tie: hand the line to whichever port did not win last time
          if (r_last_d) w_grant_i = 1'b1;
          else          w_grant_d = 1'b1;
        end else if (i_read) begin
          w_grant_i = 1'b1;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i)      w_next = ST_SERVE_I;
        else if (w_grant_d) w_next = ST_SERVE_D;
      end
      ST_SERVE_I: if (pmem_resp) w_next = ST_RESP_I;
      ST_SERVE_D: if (pmem_resp) w_next = ST_RESP_D;
      ST_RESP_I:  w_next = ST_IDLE;
      ST_RESP_D:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State, request capture and read-data capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_d   <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        r_addr   <= i_address;
        r_last_d <= 1'b0;
      end
      if (w_grant_d) begin
        r_addr     <= d_address;
        r_wdata    <= d_wdata;
        r_op_write <= d_write;   // write wins when both read and write are high
        r_last_d   <= 1'b1;
      end
      if (r_state == ST_SERVE_I && pmem_resp) begin
        r_i_rdata <= pmem_rdata;
      end
      // A writeback completion leaves the D read line untouched
      if (r_state == ST_SERVE_D && pmem_resp && !r_op_write) begin
        r_d_rdata <= pmem_rdata;
      end
    end
  end

  // Outputs are pure decodes of registered state
  assign pmem_read    = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D && !r_op_write);
  assign pmem_write   = (r_state == ST_SERVE_D) && r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_resp       = (r_state == ST_RESP_I);
  assign d_resp       = (r_state == ST_RESP_D);
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module   : tb_cache_arbiter
// Brief    : Scoreboard bench for cache_arbiter. The stimulus thread pushes
//            expected pmem commands and resp data; a negedge monitor pops and
//            compares whenever the DUT issues a command or a resp pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } cmd_t;

  cmd_t          exp_cmd[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic prev_cmd = 1'b0;
  cmd_t held;
  cmd_t cur;
  cmd_t e;

  localparam logic [LW-1:0] DA5  = {32{8'hA5}};
  localparam logic [LW-1:0] D5A  = {32{8'h5A}};
  localparam logic [LW-1:0] W1   = {8{32'h12345678}};
  localparam logic [LW-1:0] W2   = {8{32'hCAFEF00D}};
  localparam logic [LW-1:0] W3   = {8{32'h0BADBEEF}};
  localparam logic [LW-1:0] JUNK = {8{32'hDEADDEAD}};
  localparam logic [LW-1:0] T1   = {8{32'h11112222}};
  localparam logic [LW-1:0] T2   = {8{32'h33334444}};
  localparam logic [LW-1:0] T3   = {8{32'h55556666}};
  localparam logic [LW-1:0] T4   = {8{32'h77778888}};

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata;
    exp_cmd.push_back(c);
  endtask

  // Monitor: compares every new pmem command and every resp pulse to the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("pmem_rd_wr_exclusive", LW'(pmem_read & pmem_write), '0);
      if (pmem_read || pmem_write) begin
        cur.wr = pmem_write; cur.addr = pmem_address; cur.wdata = pmem_wdata;
        if (!prev_cmd) begin
          check("cmd_expected", LW'(exp_cmd.size() != 0), LW'(1));
          if (exp_cmd.size() != 0) begin
            e = exp_cmd.pop_front();
            check("cmd_op", LW'(cur.wr), LW'(e.wr));
            check("cmd_addr", LW'(cur.addr), LW'(e.addr));
            if (e.wr) check("cmd_wdata", cur.wdata, e.wdata);
            held = cur;
          end
        end else begin
          check("cmd_hold_op", LW'(cur.wr), LW'(held.wr));
          check("cmd_hold_addr", LW'(cur.addr), LW'(held.addr));
          if (held.wr) check("cmd_hold_wdata", cur.wdata, held.wdata);
        end
      end
      prev_cmd = pmem_read | pmem_write;
      check("resp_exclusive", LW'(i_resp & d_resp), '0);
      if (i_resp) begin
        check("i_resp_expected", LW'(exp_i.size() != 0), LW'(1));
        if (exp_i.size() != 0) check("i_rdata", i_rdata, exp_i.pop_front());
      end
      if (d_resp) begin
        check("d_resp_expected", LW'(exp_d.size() != 0), LW'(1));
        if (exp_d.size() != 0) check("d_rdata", d_rdata, exp_d.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until a pmem command is visible; reports cycles waited
  task automatic wait_cmd(output int waits);
    waits = 0;
    while (!(pmem_read || pmem_write) && waits < 20) begin
      tick();
      waits++;
    end
    if (waits >= 20) check("cmd_timeout", '0, LW'(1));
  endtask

  // Called in command cycle 1: return pmem_resp during command cycle n
  task automatic resp_after(input int n, input logic [LW-1:0] data);
    repeat (n - 1) tick();
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = JUNK;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = JUNK; pmem_resp = 1'b0;

    // Reset held two cycles with a pending I request
    tick(); tick();
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_pmem_address", LW'(pmem_address), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_resp", LW'(i_resp), '0);
    check("rst_d_resp", LW'(d_resp), '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    mon_en = 1'b1;

    // I read alone: command cycles 1-5, i_resp in cycle 6
    push_cmd(1'b0, 32'h0000_1000, '0);
    exp_i.push_back(DA5);
    rst = 1'b0;
    wait_cmd(w);
    check("first_grant_latency", LW'(w), LW'(1));
    resp_after(5, DA5);
    check("iread_i_resp", LW'(i_resp), LW'(1));
    check("iread_i_rdata", i_rdata, DA5);
    check("iread_d_resp", LW'(d_resp), '0);
    i_read = 1'b0;
    tick();
    check("iread_resp_one_cycle", LW'(i_resp), '0);
    check("iread_idle_no_cmd", LW'(pmem_read | pmem_write), '0);

    // D read alone
    d_read = 1'b1; d_address = 32'h0000_4000;
    push_cmd(1'b0, 32'h0000_4000, '0);
    exp_d.push_back(D5A);
    wait_cmd(w);
    check("dread_latency", LW'(w), LW'(1));
    resp_after(2, D5A);
    check("dread_d_resp", LW'(d_resp), LW'(1));
    check("dread_d_rdata", d_rdata, D5A);
    d_read = 1'b0;
    tick();

    // D writeback alone: d_rdata must keep the previous line
    d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = W1;
    push_cmd(1'b1, 32'h0000_2000, W1);
    exp_d.push_back(D5A);
    wait_cmd(w);
    check("dwrite_no_read", LW'(pmem_read), '0);
    resp_after(3, JUNK);
    check("dwrite_d_resp", LW'(d_resp), LW'(1));
    check("dwrite_d_rdata_kept", d_rdata, D5A);
    check("dwrite_i_resp", LW'(i_resp), '0);
    d_write = 1'b0;
    tick();

    // Read+write together is a write; inputs changed mid-serve are ignored
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = W2;
    push_cmd(1'b1, 32'h0000_2000, W2);
    exp_d.push_back(D5A);
    wait_cmd(w);
    d_address = 32'h0000_3000; d_wdata = W3;
    tick(); tick();
    check("midserve_addr_held", LW'(pmem_address), LW'(32'h0000_2000));
    check("midserve_wdata_held", pmem_wdata, W2);
    check("rdwr_is_write", LW'(pmem_write), LW'(1));
    resp_after(1, JUNK);
    check("midserve_d_resp", LW'(d_resp), LW'(1));
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // Stray pmem_resp in IDLE
    pmem_resp = 1'b1; pmem_rdata = JUNK;
    tick();
    pmem_resp = 1'b0;
    check("stray_i_resp", LW'(i_resp), '0);
    check("stray_d_resp", LW'(d_resp), '0);
    check("stray_no_cmd", LW'(pmem_read | pmem_write), '0);
    tick();
    check("stray_i_resp2", LW'(i_resp), '0);
    check("stray_d_resp2", LW'(d_resp), '0);
    check("stray_i_rdata_kept", i_rdata, DA5);
    check("stray_d_rdata_kept", d_rdata, D5A);

    // Reset restores round-robin pointer and clears read data
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_i_rdata", i_rdata, '0);
    check("rst2_d_rdata", d_rdata, '0);

    // Tie after reset: D first, then I (D re-requests), then D again
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    push_cmd(1'b0, 32'h0000_0200, '0);
    push_cmd(1'b0, 32'h0000_0100, '0);
    push_cmd(1'b0, 32'h0000_0240, '0);
    exp_d.push_back(T1);
    exp_i.push_back(T2);
    exp_d.push_back(T3);
    wait_cmd(w);
    check("tie1_latency", LW'(w), LW'(1));
    check("tie1_grants_d", LW'(pmem_address), LW'(32'h0000_0200));
    resp_after(2, T1);
    check("tie1_d_resp", LW'(d_resp), LW'(1));
    d_address = 32'h0000_0240;
    wait_cmd(w);
    check("tie2_one_idle_gap", LW'(w), LW'(2));
    check("tie2_grants_i", LW'(pmem_address), LW'(32'h0000_0100));
    resp_after(1, T2);
    check("tie2_i_resp", LW'(i_resp), LW'(1));
    check("tie2_min_latency_rdata", i_rdata, T2);
    i_read = 1'b0;
    wait_cmd(w);
    check("tie3_one_idle_gap", LW'(w), LW'(2));
    check("tie3_grants_d", LW'(pmem_address), LW'(32'h0000_0240));
    resp_after(1, T3);
    check("tie3_d_resp", LW'(d_resp), LW'(1));
    d_read = 1'b0;
    tick();

    // Reset in the middle of an I serve; the late pmem_resp must be dropped
    i_read = 1'b1; i_address = 32'h0000_5000;
    push_cmd(1'b0, 32'h0000_5000, '0);
    wait_cmd(w);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_read = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = JUNK;
    check("rstmid_pmem_read", LW'(pmem_read), '0);
    check("rstmid_pmem_address", LW'(pmem_address), '0);
    check("rstmid_i_resp", LW'(i_resp), '0);
    check("rstmid_i_rdata", i_rdata, '0);
    tick();
    pmem_resp = 1'b0;
    check("rstmid_no_i_resp", LW'(i_resp), '0);
    check("rstmid_i_rdata_zero", i_rdata, '0);
    tick();
    check("rstmid_no_i_resp2", LW'(i_resp), '0);

    // Normal service resumes from IDLE
    d_read = 1'b1; d_address = 32'h0000_6000;
    push_cmd(1'b0, 32'h0000_6000, '0);
    exp_d.push_back(T4);
    wait_cmd(w);
    check("post_rst_latency", LW'(w), LW'(1));
    resp_after(1, T4);
    check("post_rst_d_resp", LW'(d_resp), LW'(1));
    d_read = 1'b0;
    tick(); tick();

    check("sb_cmd_drained", LW'(exp_cmd.size()), '0);
    check("sb_i_drained", LW'(exp_i.size()), '0);
    check("sb_d_drained", LW'(exp_d.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
